// File: rtl/wrr_resource_arbiter_pkg.sv
// Shared definitions for the weighted round-robin resource arbiter.
//   state_t       : arbiter FSM states (IDLE, GRANT)
//   MAX_N         : largest supported requester count
//   idw()         : index width for a given requester count
//   onehot_to_idx : binary index of a one-hot vector (up to MAX_N bits)
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int MAX_N = 16;

    function automatic int idw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // OR of the indices of all set bits; exact for one-hot or zero input.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wrr_resource_arbiter_if.sv
// Requester/resource side bus of the weighted round-robin arbiter.
//   req[N]       : level request per requester, held until served
//   done         : pulse, current granted transaction finished
//   wt_we        : weight write strobe
//   wt_idx       : weight register index
//   wt_data[CW]  : weight value (0 is stored as 1)
//   gnt[N]       : one-hot registered grant, zero when idle
//   gnt_valid    : OR of gnt
//   gnt_id       : binary index of the granted requester
// master drives requests/done/weights, slave (the arbiter) drives the grant.
interface wrr_resource_arbiter_if #(
    parameter int N  = 4,
    parameter int CW = 4
);
    localparam int IDW = (N <= 1) ? 1 : $clog2(N);

    logic [N-1:0]   req;
    logic           done;
    logic           wt_we;
    logic [IDW-1:0] wt_idx;
    logic [CW-1:0]  wt_data;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;

    modport master (
        output req, done, wt_we, wt_idx, wt_data,
        input  gnt, gnt_valid, gnt_id
    );

    modport slave (
        input  req, done, wt_we, wt_idx, wt_data,
        output gnt, gnt_valid, gnt_id
    );

endinterface

// File: rtl/wrr_resource_arbiter_rr_pick.sv
// Combinational rotating priority picker.
//   eligible[N] : candidate vector
//   ptr         : index that has highest priority
//   found       : at least one candidate exists
//   winner      : first eligible index scanning ptr, ptr+1, .. (mod N)
// The vector is doubled and everything below ptr masked off, so the lowest
// remaining set bit is the first candidate at or after ptr with wrap-around.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   eligible,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] winner
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    always_comb begin
        dbl    = {eligible, eligible};
        masked = '0;
        for (int k = 0; k < 2 * N; k++) begin
            masked[k] = dbl[k] && (k >= int'(ptr));
        end
        found  = 1'b0;
        winner = '0;
        // Descending scan so the lowest set bit is the last one written.
        for (int k = 2 * N - 1; k >= 0; k--) begin
            if (masked[k]) begin
                found  = 1'b1;
                winner = (k >= N) ? IDW'(k - N) : IDW'(k);
            end
        end
    end

endmodule

// File: rtl/wrr_resource_arbiter.sv
// Weighted round-robin arbiter sharing one downstream resource among N
// requesters. Each requester may hold up to weight[i] consecutive
// transactions per round; the grant is held until the resource pulses done.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : slave side of wrr_resource_arbiter_if (requests, done, weight
//           writes in; registered one-hot grant, valid and index out)
module wrr_resource_arbiter #(
    parameter int N    = 4,
    parameter int CW   = 4,
    parameter int WDEF = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    wrr_resource_arbiter_if.slave bus
);
    import arb_pkg::*;

    localparam int IDW = idw(N);

    state_t         state, state_nxt;
    logic [CW-1:0]  weight      [N];
    logic [CW-1:0]  credit      [N];
    logic [CW-1:0]  credit_view [N];
    logic [CW-1:0]  credit_nxt  [N];
    logic [IDW-1:0] ptr, ptr_nxt, scan_ptr;
    logic [IDW-1:0] g;
    logic [CW-1:0]  cred_dec;
    logic           keep, repick, reload;
    logic [N-1:0]   elig;
    logic           found1, found2, win_found;
    logic [IDW-1:0] w1, w2, win;
    logic [N-1:0]   gnt_nxt;
    logic [IDW-1:0] gnt_id_nxt;
    logic           gnt_valid_nxt;

    // Current grantee taken from the one-hot grant itself.
    assign g        = IDW'(onehot_to_idx(MAX_N'(bus.gnt)));
    assign cred_dec = (credit[g] == '0) ? '0 : credit[g] - CW'(1);

    // Decision: keep the grant or re-pick, and which credits the pick sees.
    always_comb begin
        for (int i = 0; i < N; i++) credit_view[i] = credit[i];
        keep     = 1'b0;
        repick   = 1'b0;
        scan_ptr = ptr;
        case (state)
            IDLE: begin
                repick = |bus.req;
            end
            GRANT: begin
                if (bus.done) credit_view[g] = cred_dec;
                // done wins over a simultaneous request drop.
                keep   = bus.done ? (bus.req[g] && (cred_dec != '0)) : bus.req[g];
                repick = !keep;
                if (repick) scan_ptr = (g == IDW'(N - 1)) ? '0 : g + IDW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N; i++) elig[i] = bus.req[i] && (credit_view[i] != '0);
    end

    // First pick on live credits; second pick on raw requests stands in for
    // the pick after a reload, since every reloaded weight is at least 1.
    rr_pick #(.N(N), .IDW(IDW)) u_pick_credit (
        .eligible (elig),
        .ptr      (scan_ptr),
        .found    (found1),
        .winner   (w1)
    );

    rr_pick #(.N(N), .IDW(IDW)) u_pick_reload (
        .eligible (bus.req),
        .ptr      (scan_ptr),
        .found    (found2),
        .winner   (w2)
    );

    assign reload    = repick && (|bus.req) && !found1;
    assign win       = found1 ? w1 : w2;
    assign win_found = found1 || found2;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (repick) state_nxt = GRANT;
            GRANT:   if (!keep && !win_found) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next grant outputs, pointer and credits.
    always_comb begin
        gnt_nxt       = bus.gnt;
        gnt_id_nxt    = bus.gnt_id;
        gnt_valid_nxt = bus.gnt_valid;
        ptr_nxt       = ptr;
        if (repick) begin
            if (win_found) begin
                gnt_nxt    = N'(1) << win;
                gnt_id_nxt = win;
            end else begin
                gnt_nxt    = '0;
                gnt_id_nxt = '0;
            end
            gnt_valid_nxt = win_found;
            if (state == GRANT) ptr_nxt = scan_ptr;
        end
        // Reload reads the registered weights, so a same-cycle write is not seen.
        for (int i = 0; i < N; i++) credit_nxt[i] = reload ? weight[i] : credit_view[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            bus.gnt       <= '0;
            bus.gnt_valid <= 1'b0;
            bus.gnt_id    <= '0;
            for (int i = 0; i < N; i++) begin
                weight[i] <= CW'(WDEF);
                credit[i] <= CW'(WDEF);
            end
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            bus.gnt       <= gnt_nxt;
            bus.gnt_valid <= gnt_valid_nxt;
            bus.gnt_id    <= gnt_id_nxt;
            for (int i = 0; i < N; i++) credit[i] <= credit_nxt[i];
            if (bus.wt_we && (int'(bus.wt_idx) < N)) begin
                weight[bus.wt_idx] <= (bus.wt_data == '0) ? CW'(1) : bus.wt_data;
            end
        end
    end

endmodule
